// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage. Pairs preIF entries with in-order SRAM
//            responses, buffers under ID stall, and discards flushed responses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter int          CNT_W    = 2,
    parameter logic [31:0] RESET_PC = 32'h1BFFFFFC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          preIF_to_IF_valid,
    input  logic [111:0]  preIF_to_IF_BUS,
    output logic          IF_allowin,
    output logic          IF_blocked,
    output logic [31:0]   if_pc,
    input  logic          inst_sram_data_ok,
    input  logic [31:0]   inst_sram_rdata,
    input  logic          ID_allowin,
    output logic          IF_to_ID_valid,
    output logic [111:0]  IF_to_ID_BUS,
    input  logic          wb_ex,
    input  logic          ertn_flush,
    input  logic          br_taken_cancel
);

    logic             if_valid_q,       if_valid_d;
    logic             inst_buf_valid_q, inst_buf_valid_d;
    logic [31:0]      inst_buf_q,       inst_buf_d;
    logic [CNT_W-1:0] cancel_cnt_q,     cancel_cnt_d;
    logic [31:0]      if_pc_q,          if_pc_d;
    logic [31:0]      pc_q,             pc_d;
    logic             ex_q,             ex_d;
    logic [14:0]      ex_code_q,        ex_code_d;
    logic [31:0]      ex_vaddr_q,       ex_vaddr_d;

    logic        w_flush;
    logic        w_resp_hit;
    logic        w_drop;
    logic        w_ready_go;
    logic        w_allowin;
    logic        w_leave;
    logic        w_accept;
    logic        w_inc_cur;
    logic        w_inc_new;
    logic [31:0] w_inst;
    logic        w_unused;

    // pc_prev is only meaningful to preIF
    assign w_unused   = &{1'b0, preIF_to_IF_BUS[111:80]};

    assign w_flush    = wb_ex | ertn_flush | br_taken_cancel;
    assign w_resp_hit = inst_sram_data_ok && (cancel_cnt_q == '0);
    assign w_drop     = inst_sram_data_ok && (cancel_cnt_q != '0);
    assign w_ready_go = inst_buf_valid_q || w_resp_hit;
    assign w_allowin  = !if_valid_q || (w_ready_go && ID_allowin);
    assign w_leave    = if_valid_q && w_ready_go && ID_allowin;
    assign w_accept   = preIF_to_IF_valid && w_allowin;
    assign w_inst     = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;

    // Requests abandoned by a flush: the current entry if its response is
    // still outstanding, and any entry handed over in the flush cycle.
    assign w_inc_cur  = if_valid_q && !inst_buf_valid_q && !w_resp_hit;
    assign w_inc_new  = w_accept;

    assign IF_allowin     = w_allowin;
    assign IF_blocked     = !reset && w_allowin && !w_flush;
    assign if_pc          = if_pc_q;
    assign IF_to_ID_valid = if_valid_q && w_ready_go && !w_flush;
    assign IF_to_ID_BUS   = {pc_q, w_inst, ex_q, ex_code_q, ex_vaddr_q};

    always_comb begin
        if_valid_d       = if_valid_q;
        inst_buf_valid_d = inst_buf_valid_q;
        inst_buf_d       = inst_buf_q;
        cancel_cnt_d     = cancel_cnt_q - CNT_W'(w_drop);
        if_pc_d          = if_pc_q;
        pc_d             = pc_q;
        ex_d             = ex_q;
        ex_code_d        = ex_code_q;
        ex_vaddr_d       = ex_vaddr_q;

        if (w_flush) begin
            if_valid_d       = 1'b0;
            inst_buf_valid_d = 1'b0;
            cancel_cnt_d     = cancel_cnt_q + CNT_W'(w_inc_cur) + CNT_W'(w_inc_new)
                               - CNT_W'(w_drop);
        end else begin
            if (w_accept) begin
                if_valid_d = 1'b0 | 1'b1;
                if_pc_d    = preIF_to_IF_BUS[79:48];
                pc_d       = preIF_to_IF_BUS[79:48];
                ex_d       = preIF_to_IF_BUS[47];
                ex_code_d  = preIF_to_IF_BUS[46:32];
                ex_vaddr_d = preIF_to_IF_BUS[31:0];
            end else if (w_leave) begin
                if_valid_d = 1'b0;
            end

            if (w_leave) begin
                inst_buf_valid_d = 1'b0;
            end else if (w_resp_hit && if_valid_q && !inst_buf_valid_q && !ID_allowin) begin
                inst_buf_valid_d = 1'b1;
                inst_buf_d       = inst_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid_q       <= 1'b0;
            inst_buf_valid_q <= 1'b0;
            inst_buf_q       <= '0;
            cancel_cnt_q     <= '0;
            if_pc_q          <= RESET_PC;
            pc_q             <= '0;
            ex_q             <= 1'b0;
            ex_code_q        <= '0;
            ex_vaddr_q       <= '0;
        end else begin
            if_valid_q       <= if_valid_d;
            inst_buf_valid_q <= inst_buf_valid_d;
            inst_buf_q       <= inst_buf_d;
            cancel_cnt_q     <= cancel_cnt_d;
            if_pc_q          <= if_pc_d;
            pc_q             <= pc_d;
            ex_q             <= ex_d;
            ex_code_q        <= ex_code_d;
            ex_vaddr_q       <= ex_vaddr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed self-checking bench for if_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0]  c_RESET_PC  = 32'h1BFFFFFC;
    localparam logic [111:0] c_INST_MASK = {32'h0, 32'hFFFFFFFF, 48'h0};
    localparam logic [14:0]  c_ADEF      = 15'h0008;

    logic         clk = 1'b0;
    logic         reset;
    logic         preIF_to_IF_valid;
    logic [111:0] preIF_to_IF_BUS;
    logic         IF_allowin;
    logic         IF_blocked;
    logic [31:0]  if_pc;
    logic         inst_sram_data_ok;
    logic [31:0]  inst_sram_rdata;
    logic         ID_allowin;
    logic         IF_to_ID_valid;
    logic [111:0] IF_to_ID_BUS;
    logic         wb_ex;
    logic         ertn_flush;
    logic         br_taken_cancel;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage #(.CNT_W(2), .RESET_PC(c_RESET_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .preIF_to_IF_valid (preIF_to_IF_valid),
        .preIF_to_IF_BUS   (preIF_to_IF_BUS),
        .IF_allowin        (IF_allowin),
        .IF_blocked        (IF_blocked),
        .if_pc             (if_pc),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .ID_allowin        (ID_allowin),
        .IF_to_ID_valid    (IF_to_ID_valid),
        .IF_to_ID_BUS      (IF_to_ID_BUS),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .br_taken_cancel   (br_taken_cancel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [111:0] mk_in(input logic [31:0] pc, input logic ex,
                                           input logic [14:0] code, input logic [31:0] va);
        return {pc - 32'd4, pc, ex, code, va};
    endfunction

    function automatic logic [111:0] mk_out(input logic [31:0] pc, input logic [31:0] inst,
                                            input logic ex, input logic [14:0] code,
                                            input logic [31:0] va);
        return {pc, inst, ex, code, va};
    endfunction

    task automatic idle();
        preIF_to_IF_valid = 1'b0;
        preIF_to_IF_BUS   = '0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'hFFFFFFFF;
        ID_allowin        = 1'b1;
        wb_ex             = 1'b0;
        ertn_flush        = 1'b0;
        br_taken_cancel   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handoff(input logic [31:0] pc);
        idle();
        preIF_to_IF_valid = 1'b1;
        preIF_to_IF_BUS   = mk_in(pc, 1'b0, 15'h0, pc);
        tick();
    endtask

    // Stale-response counter must stay within two in legal operation
    always @(negedge clk) begin
        if (!reset) check("cnt_max", 112'(dut.cancel_cnt_q <= 2'd2), 112'd1);
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_valid",   112'(IF_to_ID_valid), 112'd0);
        check("rst_allowin", 112'(IF_allowin), 112'd1);
        check("rst_blocked", 112'(IF_blocked), 112'd0);
        check("rst_pc",      112'(if_pc), 112'(c_RESET_PC));
        check("rst_bus",     IF_to_ID_BUS & ~c_INST_MASK, 112'd0);
        reset = 1'b0;
        #1;
        check("post_rst_blocked", 112'(IF_blocked), 112'd1);

        // Zero-latency pass-through
        handoff(32'h1C000000);
        idle();
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h02800C0C;
        #1;
        check("pass_valid", 112'(IF_to_ID_valid), 112'd1);
        check("pass_bus",   IF_to_ID_BUS, mk_out(32'h1C000000, 32'h02800C0C, 1'b0, 15'h0, 32'h1C000000));
        check("pass_allow", 112'(IF_allowin), 112'd1);
        check("pass_ifpc",  112'(if_pc), 112'h1C000000);
        tick();
        idle();
        #1;
        check("pass_gone", 112'(IF_to_ID_valid), 112'd0);

        // Stall: response buffered and held while ID is blocked
        handoff(32'h1C000010);
        idle();
        ID_allowin        = 1'b0;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h12345678;
        #1;
        check("stall_v0",     112'(IF_to_ID_valid), 112'd1);
        check("stall_allow0", 112'(IF_allowin), 112'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            ID_allowin = 1'b0;
            #1;
            check("stall_v",     112'(IF_to_ID_valid), 112'd1);
            check("stall_inst",  112'(IF_to_ID_BUS[79:48]), 112'h12345678);
            check("stall_allow", 112'(IF_allowin), 112'd0);
            tick();
        end
        idle();
        #1;
        check("release_v",     112'(IF_to_ID_valid), 112'd1);
        check("release_bus",   IF_to_ID_BUS, mk_out(32'h1C000010, 32'h12345678, 1'b0, 15'h0, 32'h1C000010));
        check("release_allow", 112'(IF_allowin), 112'd1);
        tick();
        idle();
        #1;
        check("release_gone", 112'(IF_to_ID_valid), 112'd0);

        // Branch cancel with response outstanding
        handoff(32'h1C000004);
        idle();
        br_taken_cancel = 1'b1;
        #1;
        check("br_valid",   112'(IF_to_ID_valid), 112'd0);
        check("br_blocked", 112'(IF_blocked), 112'd0);
        tick();
        idle();
        #1;
        check("br_cnt1", 112'(dut.cancel_cnt_q), 112'd1);
        preIF_to_IF_valid = 1'b1;
        preIF_to_IF_BUS   = mk_in(32'h1C000100, 1'b0, 15'h0, 32'h1C000100);
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'hDEADBEEF;
        #1;
        check("br_drop_v", 112'(IF_to_ID_valid), 112'd0);
        tick();
        idle();
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h11111111;
        #1;
        check("br_cnt0", 112'(dut.cancel_cnt_q), 112'd0);
        check("br_next", IF_to_ID_BUS, mk_out(32'h1C000100, 32'h11111111, 1'b0, 15'h0, 32'h1C000100));
        check("br_next_v", 112'(IF_to_ID_valid), 112'd1);
        tick();

        // Flush coinciding with the current entry's response
        handoff(32'h1C000180);
        idle();
        br_taken_cancel   = 1'b1;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h22222222;
        #1;
        check("fr_valid", 112'(IF_to_ID_valid), 112'd0);
        tick();
        idle();
        #1;
        check("fr_cnt", 112'(dut.cancel_cnt_q), 112'd0);
        check("fr_gone", 112'(IF_to_ID_valid), 112'd0);

        // wb_ex held across a pending entry and a preIF handoff
        handoff(32'h1C000200);
        idle();
        wb_ex             = 1'b1;
        preIF_to_IF_valid = 1'b1;
        preIF_to_IF_BUS   = mk_in(32'h1C000204, 1'b0, 15'h0, 32'h1C000204);
        tick();
        #1;
        check("ex_cnt1", 112'(dut.cancel_cnt_q), 112'd1);
        tick();
        idle();
        #1;
        check("ex_cnt2", 112'(dut.cancel_cnt_q), 112'd2);
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h55555555;
        #1;
        check("ex_drop1", 112'(IF_to_ID_valid), 112'd0);
        tick();
        idle();
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h66666666;
        preIF_to_IF_valid = 1'b1;
        preIF_to_IF_BUS   = mk_in(32'h1C000300, 1'b0, 15'h0, 32'h1C000300);
        #1;
        check("ex_cnt_dec", 112'(dut.cancel_cnt_q), 112'd1);
        check("ex_drop2", 112'(IF_to_ID_valid), 112'd0);
        tick();
        idle();
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'hAABBCCDD;
        #1;
        check("ex_third_v", 112'(IF_to_ID_valid), 112'd1);
        check("ex_third",   IF_to_ID_BUS, mk_out(32'h1C000300, 32'hAABBCCDD, 1'b0, 15'h0, 32'h1C000300));
        tick();

        // ADEF entry waits for its own response
        idle();
        preIF_to_IF_valid = 1'b1;
        preIF_to_IF_BUS   = mk_in(32'h1C000002, 1'b1, c_ADEF, 32'h1C000002);
        tick();
        idle();
        #1;
        check("adef_wait",  112'(IF_to_ID_valid), 112'd0);
        check("adef_allow", 112'(IF_allowin), 112'd0);
        tick();
        idle();
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h00000000;
        #1;
        check("adef_v",   112'(IF_to_ID_valid), 112'd1);
        check("adef_bus", IF_to_ID_BUS, mk_out(32'h1C000002, 32'h0, 1'b1, c_ADEF, 32'h1C000002));
        tick();

        // Reset with a stale response outstanding
        handoff(32'h1C000400);
        idle();
        br_taken_cancel = 1'b1;
        tick();
        idle();
        #1;
        check("pre_rst_cnt", 112'(dut.cancel_cnt_q), 112'd1);
        reset = 1'b1;
        tick();
        check("mrst_cnt",     112'(dut.cancel_cnt_q), 112'd0);
        check("mrst_valid",   112'(IF_to_ID_valid), 112'd0);
        check("mrst_allowin", 112'(IF_allowin), 112'd1);
        check("mrst_blocked", 112'(IF_blocked), 112'd0);
        check("mrst_pc",      112'(if_pc), 112'(c_RESET_PC));
        check("mrst_bus",     IF_to_ID_BUS & ~c_INST_MASK, 112'd0);
        reset = 1'b0;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h33333333;
        #1;
        check("orphan_v", 112'(IF_to_ID_valid), 112'd0);
        tick();
        idle();
        #1;
        check("orphan_cnt", 112'(dut.cancel_cnt_q), 112'd0);
        check("orphan_gone", 112'(IF_to_ID_valid), 112'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch (IF) stage of the LoongArch pipeline, sitting between preIF_stage and the decode stage.
- Accepts one fetch entry per addr_ok'ed instruction-SRAM request from preIF.
- Waits for the matching `inst_sram_data_ok` response and buffers the instruction while ID stalls, then hands {pc, inst, exception} to ID.
- Counts and silently drops responses belonging to requests killed by exception, ertn or branch flushes.

## Interface
Parameters:
- CNT_W, 2, width of discard counter (max 3 pending stale responses)
- RESET_PC, 32'h1BFFFFFC, reset value of if_pc

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- preIF_to_IF_valid  in  1  preIF entry valid (request already accepted by addr_ok)
- preIF_to_IF_BUS  in  112  {pc_prev[31:0], pc[31:0], ex, ex_code[14:0], ex_vaddr[31:0]}; IF uses pc, ex, ex_code, ex_vaddr
- IF_allowin  out  1  IF can latch a preIF entry this cycle
- IF_blocked  out  1  fetch permission to preIF; high = preIF may issue a request
- if_pc  out  32  pc of current IF entry (preIF seq_pc base)
- inst_sram_data_ok  in  1  response valid, in request order
- inst_sram_rdata  in  32  response data
- ID_allowin  in  1  decode can accept
- IF_to_ID_valid  out  1  entry handed to ID
- IF_to_ID_BUS  out  112  {pc[31:0], inst[31:0], ex, ex_code[14:0], ex_vaddr[31:0]}
- wb_ex, ertn_flush, br_taken_cancel  in  1 each  flush sources; flush = OR of the three

## Operation
- State: if_valid, latched pc/ex/ex_code/ex_vaddr, inst_buf_valid + inst_buf[31:0], cancel_cnt[CNT_W-1:0].
- Every preIF entry owns exactly one response, including ex entries; the ex fields are passed through unchanged.
- resp_hit = inst_sram_data_ok && cancel_cnt==0; data_ok with cancel_cnt>0 is dropped and cancel_cnt decrements.
- if_ready_go = inst_buf_valid || resp_hit.
- IF_allowin = !if_valid || (if_ready_go && ID_allowin).
- IF_to_ID_valid = if_valid && if_ready_go && !flush.
- inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
- Capture: if resp_hit && if_valid && !ID_allowin && !flush, then inst_buf <= rdata and inst_buf_valid <= 1. inst_buf_valid clears when the entry leaves IF or on flush.
- Latch: preIF_to_IF_valid && IF_allowin && !flush loads the bus fields and sets if_valid; otherwise if_valid clears when the entry leaves.
- Flush: if_valid <= 0, inst_buf_valid <= 0. Stale increment:
  - +1 if if_valid && !inst_buf_valid && !resp_hit
  - +1 if preIF_to_IF_valid && IF_allowin (the incoming request is discarded)
  - minus 1 if data_ok was dropped that cycle
  - The net increment/decrement is applied in one update.
- Responses return in order, so stale responses always precede new ones.
- IF_blocked = !reset && IF_allowin && !flush.
- if_pc holds the last latched pc; it is not changed by a flush.

## Timing
- Reset values:
  - if_valid 0, inst_buf_valid 0, cancel_cnt 0, if_pc RESET_PC
  - IF_to_ID_valid 0, IF_allowin 1, IF_blocked 0
  - IF_to_ID_BUS fields other than inst are 0.
- Zero-latency pass-through: data_ok in cycle N with ID_allowin gives IF_to_ID_valid in cycle N and new entry acceptance in cycle N.
- Stalled response appears from inst_buf in cycle N+1 onward; it is held stable until ID_allowin.
- Reset mid-operation clears all state including cancel_cnt; a response arriving after reset with no entry is ignored.
- Simultaneous flush and data_ok for the current entry: the response is consumed, not counted, and not forwarded.
- Simultaneous flush and a preIF handoff: the entry is not latched and cancel_cnt increments.
- cancel_cnt never exceeds 2 in legal operation; the bench asserts this.

## Test plan
- Reset, then entry pc=0x1C000000 handed off; data_ok next cycle with rdata=0x02800C0C and ID_allowin=1 -> IF_to_ID_valid same cycle, bus {0x1C000000, 0x02800C0C, 0, 0, 0x1C000000}.
- ID_allowin=0 when data_ok arrives with rdata=0x12345678 -> inst_buf holds it, IF_to_ID_valid stays 1 with inst 0x12345678 for 3 stalled cycles, IF_allowin=0; released when ID_allowin=1.
- br_taken_cancel while entry 0x1C000004 awaits response -> cancel_cnt=1; next data_ok (0xDEADBEEF) dropped; following entry 0x1C000100 receives next response.
- wb_ex in the same cycle as a preIF handoff with IF entry pending -> cancel_cnt=2; two data_ok dropped, third forwarded.
- ADEF entry (pc=0x1C000002, ex=1, ex_code=ADEF) -> forwarded only after its data_ok, ex fields intact.
- Reset asserted with cancel_cnt=1 -> all outputs return to reset values the next cycle and cancel_cnt=0.
